// File: rtl/gc_multi_engine_scheduler_pkg.sv
// gc_multi_engine_scheduler_pkg: gate-type codes, scheduler FSM states and the free-XOR classifier
// Shared by the scheduler top and the bench; no ports.
package gc_multi_engine_scheduler_pkg;
   typedef enum logic [3:0] {
      G_AND  = 4'd0,
      G_XOR  = 4'd1,
      G_XNOR = 4'd2,
      G_NOT  = 4'd3,
      G_OR   = 4'd4,
      G_NAND = 4'd5,
      G_NOR  = 4'd6
   } gate_t;
   typedef enum logic [2:0] {ST_IDLE, ST_KEYS, ST_RUN, ST_DRAIN, ST_DONE} state_t;
   function automatic logic is_free_xor(logic [3:0] g);
      return g == G_XOR || g == G_XNOR || g == G_NOT;
   endfunction
endpackage

// File: rtl/gc_lane_slot.sv
// gc_lane_slot: one GC engine lane record with fixed-latency countdown
// Ports: clk/rst; issue + issue_* record fields in; busy, retire (one-cycle,
// LAT cycles after issue) and the latched record (gid, gt_idx, is_output, om_idx) out.
module gc_lane_slot #(
   parameter int S    = 20,
   parameter int OM_W = 16,
   parameter int LAT  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue,
   input  logic [S-1:0]    issue_gid,
   input  logic [S-1:0]    issue_gt,
   input  logic            issue_out,
   input  logic [OM_W-1:0] issue_om,
   output logic            busy,
   output logic            retire,
   output logic [S-1:0]    gid,
   output logic [S-1:0]    gt_idx,
   output logic            is_output,
   output logic [OM_W-1:0] om_idx
);
   localparam int CW = $clog2(LAT) + 1;
   logic [CW-1:0] cnt;
   // Loading LAT-1 makes the retire cycle land exactly LAT cycles after issue.
   assign retire = busy && cnt == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         cnt       <= '0;
         gid       <= '0;
         gt_idx    <= '0;
         is_output <= 1'b0;
         om_idx    <= '0;
      end else if (issue) begin
         busy      <= 1'b1;
         cnt       <= CW'(LAT - 1);
         gid       <= issue_gid;
         gt_idx    <= issue_gt;
         is_output <= issue_out;
         om_idx    <= issue_om;
      end else if (retire) begin
         busy <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/gc_multi_engine_scheduler.sv
// gc_multi_engine_scheduler: in-order gate issue to NE fixed-latency GC lanes with local free-XOR
// Ports: start/keys_ok run control; g_* gate stream (valid/ready); op_rdy0/1 operand
// label flags; eng_* lane issue; xor_/ol_/gt_/om_wr_* write strobes; busy, done.
// Optional GC_PERF_CNT_EN adds saturating stall_dep_cnt / stall_lane_cnt.
module gc_multi_engine_scheduler
   import gc_multi_engine_scheduler_pkg::*;
#(
   parameter int S    = 20,
   parameter int NE   = 2,
   parameter int LAT  = 10,
   parameter int OM_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            keys_ok,
   input  logic            g_valid,
   output logic            g_ready,
   input  logic            g_last,
   input  logic [3:0]      g_logic,
   input  logic [S-1:0]    g_in0,
   input  logic [S-1:0]    g_in1,
   input  logic            g_in0F,
   input  logic            g_in1F,
   input  logic            g_is_output,
   input  logic            op_rdy0,
   input  logic            op_rdy1,
   output logic [NE-1:0]   eng_issue,
   output logic [S-1:0]    eng_gid,
   output logic [3:0]      eng_logic,
   output logic            xor_wr_en,
   output logic [S-1:0]    xor_wr_addr,
   output logic            ol_wr_en,
   output logic [S-1:0]    ol_wr_addr,
   output logic            gt_wr_en,
   output logic [S:0]      gt_wr_addr,
   output logic            om_wr_en,
   output logic            om_wr_sel_xor,
   output logic [OM_W-1:0] om_wr_idx,
   output logic            busy,
   output logic            done
`ifdef GC_PERF_CNT_EN
   ,
   output logic [31:0]     stall_dep_cnt,
   output logic [31:0]     stall_lane_cnt
`endif
);
   state_t state, state_nxt;
   logic [S-1:0] gid, num_xor;
   logic [OM_W-1:0] om_cnt;
   logic [NE-1:0] l_busy, l_ret, l_out, l_free, grant;
   logic [S-1:0] l_gid [NE];
   logic [S-1:0] l_gt [NE];
   logic [OM_W-1:0] l_om [NE];
   logic [S-1:0] ret_gid, ret_gt;
   logic [OM_W-1:0] ret_om_idx;
   logic ret_any, ret_out, ret_om, op_ok, fx, head, xor_acc, and_acc, xor_om;
   logic unused_in0;
   assign unused_in0 = ^g_in0;
   for (genvar i = 0; i < NE; i++) begin : g_lane
      gc_lane_slot #(.S(S), .OM_W(OM_W), .LAT(LAT)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .issue     (eng_issue[i]),
         .issue_gid (gid),
         .issue_gt  (gid - num_xor),
         .issue_out (g_is_output),
         .issue_om  (om_cnt),
         .busy      (l_busy[i]),
         .retire    (l_ret[i]),
         .gid       (l_gid[i]),
         .gt_idx    (l_gt[i]),
         .is_output (l_out[i]),
         .om_idx    (l_om[i])
      );
   end
   // A retiring lane counts as free so it can be reissued in the same cycle.
   always_comb begin
      l_free     = ~l_busy | l_ret;
      grant      = l_free & (~l_free + NE'(1));
      ret_gid    = '0;
      ret_gt     = '0;
      ret_out    = 1'b0;
      ret_om_idx = '0;
      for (int k = 0; k < NE; k++) begin
         if (l_ret[k]) begin
            ret_gid    = l_gid[k];
            ret_gt     = l_gt[k];
            ret_out    = l_out[k];
            ret_om_idx = l_om[k];
         end
      end
   end
   assign ret_any = |l_ret;
   assign ret_om  = ret_any & ret_out;
   // g_in1 all-ones is the constant-R operand, which never waits for a label.
   assign op_ok   = (g_in0F | op_rdy0) & (&g_in1 | g_in1F | op_rdy1);
   assign fx      = is_free_xor(g_logic);
   assign head    = (state == ST_RUN) & g_valid & op_ok;
   // An output XOR yields the mask port to a retiring output lane.
   assign xor_acc = head & fx & ~(g_is_output & ret_om);
   assign and_acc = head & ~fx & |l_free;
   assign xor_om  = xor_acc & g_is_output;
   assign g_ready       = xor_acc | and_acc;
   assign eng_issue     = and_acc ? grant : '0;
   assign eng_gid       = and_acc ? gid : '0;
   assign eng_logic     = and_acc ? g_logic : '0;
   assign xor_wr_en     = xor_acc;
   assign xor_wr_addr   = xor_acc ? gid : '0;
   assign ol_wr_en      = ret_any;
   assign ol_wr_addr    = ret_gid;
   assign gt_wr_en      = ret_any;
   assign gt_wr_addr    = {ret_gt, 1'b0};
   assign om_wr_en      = ret_om | xor_om;
   assign om_wr_sel_xor = ~ret_om & xor_om;
   assign om_wr_idx     = ret_om ? ret_om_idx : (xor_om ? om_cnt : '0);
   assign busy          = state == ST_KEYS || state == ST_RUN || state == ST_DRAIN;
   assign done          = state == ST_DONE;
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_KEYS;
         ST_KEYS:  if (keys_ok) state_nxt = ST_RUN;
         ST_RUN:   if (g_ready & g_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (&l_free) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         gid     <= '0;
         num_xor <= '0;
         om_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            gid     <= '0;
            num_xor <= '0;
            om_cnt  <= '0;
         end else begin
            if (g_ready) gid <= gid + 1'b1;
            if (xor_acc) num_xor <= num_xor + 1'b1;
            if (g_ready & g_is_output) om_cnt <= om_cnt + 1'b1;
         end
      end
   end
`ifdef GC_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || (state == ST_IDLE && start)) begin
         stall_dep_cnt  <= '0;
         stall_lane_cnt <= '0;
      end else begin
         if (state == ST_RUN && g_valid && !op_ok && !(&stall_dep_cnt))
            stall_dep_cnt <= stall_dep_cnt + 1'b1;
         if (state == ST_RUN && g_valid && op_ok && !fx && !(|l_free) && !(&stall_lane_cnt))
            stall_lane_cnt <= stall_lane_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_gc_multi_engine_scheduler.sv
// tb_gc_multi_engine_scheduler: randomized and directed gate streams checked against an event-level model
module tb_gc_multi_engine_scheduler;
   import gc_multi_engine_scheduler_pkg::*;
   localparam int S = 20, NE = 2, LAT = 10, OM_W = 16;
   typedef struct {logic [3:0] lg; bit c1; bit f0; bit f1; bit out;} gate_rec_t;
   logic clk = 0, rst = 1, start = 0, keys_ok = 0, g_valid = 0, g_last = 0;
   logic [3:0] g_logic = '0;
   logic [S-1:0] g_in0 = '0, g_in1 = '0;
   logic g_in0F = 0, g_in1F = 0, g_is_output = 0, op_rdy0 = 0, op_rdy1 = 0;
   logic g_ready, xor_wr_en, ol_wr_en, gt_wr_en, om_wr_en, om_wr_sel_xor, busy, done;
   logic [NE-1:0] eng_issue;
   logic [S-1:0] eng_gid, xor_wr_addr, ol_wr_addr;
   logic [3:0] eng_logic;
   logic [S:0] gt_wr_addr;
   logic [OM_W-1:0] om_wr_idx;
   gc_multi_engine_scheduler #(.S(S), .NE(NE), .LAT(LAT), .OM_W(OM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .keys_ok(keys_ok), .g_valid(g_valid), .g_ready(g_ready),
      .g_last(g_last), .g_logic(g_logic), .g_in0(g_in0), .g_in1(g_in1), .g_in0F(g_in0F), .g_in1F(g_in1F),
      .g_is_output(g_is_output), .op_rdy0(op_rdy0), .op_rdy1(op_rdy1), .eng_issue(eng_issue),
      .eng_gid(eng_gid), .eng_logic(eng_logic), .xor_wr_en(xor_wr_en), .xor_wr_addr(xor_wr_addr),
      .ol_wr_en(ol_wr_en), .ol_wr_addr(ol_wr_addr), .gt_wr_en(gt_wr_en), .gt_wr_addr(gt_wr_addr),
      .om_wr_en(om_wr_en), .om_wr_sel_xor(om_wr_sel_xor), .om_wr_idx(om_wr_idx), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   int errors = 0, checks = 0;
   int ms, cyc, gid, nx, om, hold1, rst_at, rst_dly, run_at, last_ret, done_at, ol_cnt;
   bit mb[NE];
   bit mout[NE];
   int mr[NE], mgid[NE], mgt[NE], mom[NE];
   gate_rec_t q[$];
   int gt_log[$], iss_log[$], xor_log[$], om_idx_log[$], om_sel_log[$], om_cyc_log[$];
   logic [3:0] types[6] = '{G_AND, G_OR, G_XOR, G_XNOR, G_NOT, G_NAND};
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic model_reset();
      ms = 0; gid = 0; nx = 0; om = 0;
      for (int l = 0; l < NE; l++) mb[l] = 0;
   endtask
   // One clock: drive inputs, predict outputs from pending lane events, compare, advance the model.
   task automatic cycle(bit do_start, int p_v, int p_r);
      int rl, fl;
      bit rdy, fx, romc, xacc, aacc, allfree;
      gate_rec_t h;
      h = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      if (q.size() > 0) h = q[0];
      start = do_start;
      keys_ok = ($urandom_range(0, 2) == 0);
      rst = (rst_at >= 0 && cyc == rst_at);
      g_valid = q.size() > 0 && $urandom_range(1, 100) <= p_v;
      g_last = q.size() == 1;
      g_logic = h.lg;
      g_in0 = S'($urandom);
      g_in1 = h.c1 ? '1 : S'($urandom_range(0, 1000));
      g_in0F = h.f0; g_in1F = h.f1; g_is_output = h.out;
      op_rdy0 = $urandom_range(1, 100) <= p_r;
      op_rdy1 = $urandom_range(1, 100) <= p_r;
      if (ms == 2 && g_valid && hold1 > 0) begin op_rdy1 = 0; hold1--; end
      rl = -1; fl = -1; allfree = 1;
      for (int l = 0; l < NE; l++) begin
         if (mb[l] && mr[l] == cyc) rl = l;
         if (!mb[l] || mr[l] == cyc) begin
            if (fl < 0) fl = l;
         end else allfree = 0;
      end
      rdy = (h.f0 || op_rdy0) && (h.c1 || h.f1 || op_rdy1);
      fx = h.lg inside {G_XOR, G_XNOR, G_NOT};
      romc = rl >= 0 && mout[rl];
      xacc = ms == 2 && g_valid && rdy && fx && !(h.out && romc);
      aacc = ms == 2 && g_valid && rdy && !fx && fl >= 0;
      @(negedge clk);
      chk("g_ready", g_ready, xacc || aacc);
      chk("eng_issue", eng_issue, aacc ? (1 << fl) : 0);
      if (aacc) begin chk("eng_gid", eng_gid, gid); chk("eng_logic", eng_logic, h.lg); end
      chk("xor_wr_en", xor_wr_en, xacc);
      if (xacc) chk("xor_wr_addr", xor_wr_addr, gid);
      chk("ol_wr_en", ol_wr_en, rl >= 0);
      chk("gt_wr_en", gt_wr_en, rl >= 0);
      if (rl >= 0) begin
         chk("ol_wr_addr", ol_wr_addr, mgid[rl]);
         chk("gt_wr_addr", gt_wr_addr, 2 * mgt[rl]);
      end
      chk("om_wr_en", om_wr_en, romc || (xacc && h.out));
      if (romc) begin chk("om_sel", om_wr_sel_xor, 0); chk("om_idx", om_wr_idx, mom[rl]); end
      else if (xacc && h.out) begin chk("om_sel", om_wr_sel_xor, 1); chk("om_idx", om_wr_idx, om); end
      chk("busy", busy, ms == 1 || ms == 2 || ms == 3);
      chk("done", done, ms == 4);
      if (gt_wr_en) gt_log.push_back(int'(gt_wr_addr));
      if (|eng_issue) begin
         iss_log.push_back(cyc);
         if (rst_dly >= 0 && rst_at < 0) rst_at = cyc + rst_dly;
      end
      if (xor_wr_en) xor_log.push_back(int'(xor_wr_addr));
      if (om_wr_en) begin
         om_idx_log.push_back(int'(om_wr_idx));
         om_sel_log.push_back(int'(om_wr_sel_xor));
         om_cyc_log.push_back(cyc);
      end
      if (ol_wr_en) begin last_ret = cyc; ol_cnt++; end
      if (done) done_at = cyc;
      @(posedge clk); #1;
      if (rst) begin
         model_reset();
         q.delete();
      end else begin
         case (ms)
            0: if (do_start) begin ms = 1; gid = 0; nx = 0; om = 0; end
            1: if (keys_ok) begin ms = 2; run_at = cyc + 1; end
            2: if ((xacc || aacc) && g_last) ms = 3;
            3: if (allfree) ms = 4;
            default: ms = 0;
         endcase
         if (rl >= 0) mb[rl] = 0;
         if (aacc) begin
            mb[fl] = 1; mr[fl] = cyc + LAT; mgid[fl] = gid; mgt[fl] = gid - nx;
            mout[fl] = h.out; mom[fl] = om;
         end
         if (xacc) nx++;
         if ((xacc || aacc) && h.out) om++;
         if (xacc || aacc) begin gid++; void'(q.pop_front()); end
      end
      cyc++;
   endtask
   task automatic scenario(int p_v, int p_r);
      int n;
      gt_log.delete(); iss_log.delete(); xor_log.delete();
      om_idx_log.delete(); om_sel_log.delete(); om_cyc_log.delete();
      last_ret = -1; done_at = -1; ol_cnt = 0; run_at = -1;
      cycle(1, p_v, p_r);
      n = 0;
      while (ms != 0 && n < 4000) begin
         cycle($urandom_range(0, 7) == 0, p_v, p_r);
         n++;
      end
      chk("timeout", ms, 0);
   endtask
   initial begin
      rst_at = -1; rst_dly = -1; hold1 = 0; cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_g_ready", g_ready, 0);
      chk("rst_issue", eng_issue, 0);
      chk("rst_ol", ol_wr_en, 0);
      chk("rst_om", om_wr_en, 0);
      @(posedge clk); #1;
      rst = 0;
      // three independent ANDs: third waits for lane 0 to retire
      repeat (3) q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b0});
      scenario(100, 100);
      chk("t1_gt_n", gt_log.size(), 3);
      if (gt_log.size() == 3 && iss_log.size() == 3) begin
         chk("t1_gt0", gt_log[0], 0);
         chk("t1_gt1", gt_log[1], 2);
         chk("t1_gt2", gt_log[2], 4);
         chk("t1_b2b", iss_log[1] - iss_log[0], 1);
         chk("t1_reissue", iss_log[2] - iss_log[0], LAT);
      end
      chk("t1_done_gap", done_at - last_ret, 1);
      // AND, XOR, AND: XOR skips a table slot
      q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b0});
      q.push_back('{G_XOR, 1'b1, 1'b1, 1'b0, 1'b0});
      q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b0});
      scenario(100, 100);
      chk("t2_xor_n", xor_log.size(), 1);
      chk("t2_gt_n", gt_log.size(), 2);
      if (xor_log.size() == 1 && gt_log.size() == 2) begin
         chk("t2_xor_gid", xor_log[0], 1);
         chk("t2_gt0", gt_log[0], 0);
         chk("t2_gt1", gt_log[1], 2);
      end
      // operand 1 label missing for 5 cycles
      q.push_back('{G_AND, 1'b0, 1'b1, 1'b0, 1'b0});
      hold1 = 5;
      scenario(100, 100);
      if (iss_log.size() > 0) chk("t3_dep_stall", iss_log[0] - run_at, 5);
      else chk("t3_issued", 0, 1);
      // output AND then output XOR
      q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b1});
      q.push_back('{G_XOR, 1'b1, 1'b1, 1'b0, 1'b1});
      scenario(100, 100);
      chk("t4_om_n", om_idx_log.size(), 2);
      if (om_idx_log.size() == 2 && iss_log.size() == 1) begin
         chk("t4_idx0", om_idx_log[0], 1);
         chk("t4_sel0", om_sel_log[0], 1);
         chk("t4_xor_at", om_cyc_log[0] - iss_log[0], 1);
         chk("t4_idx1", om_idx_log[1], 0);
         chk("t4_sel1", om_sel_log[1], 0);
         chk("t4_and_at", om_cyc_log[1] - iss_log[0], LAT);
      end
      // reset three cycles after the first issue
      q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b0});
      q.push_back('{G_AND, 1'b1, 1'b1, 1'b0, 1'b0});
      rst_dly = 3;
      scenario(100, 100);
      rst_dly = -1; rst_at = -1; ol_cnt = 0;
      repeat (LAT + 5) cycle(0, 100, 100);
      chk("t5_no_ol", ol_cnt, 0);
      chk("t5_busy", busy, 0);
      // random streams
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(5, 40);
         for (int k = 0; k < n; k++)
            q.push_back('{types[$urandom_range(0, 5)], $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0});
         scenario($urandom_range(40, 100), $urandom_range(40, 100));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gc_multi_engine_scheduler.md
Name: gc_multi_engine_scheduler

Overview:
- Gate-issue controller for the garbler, generalised from a single GC engine to NE non-pipelined GC engine lanes.
- Consumes the netlist gate stream in gid order and stalls on operand-label readiness.
- Handles XOR/XNOR/NOT gates locally (free-XOR). Dispatches all other gates to the lowest free engine lane.
- Generates label, garbled-table and output-mask write strobes and addresses. Sits between Netlist and the engine/DPRAM datapath.

Parameters:
S, 20, gate/wire index width
NE, 2, number of GC engine lanes (1..8)
LAT, 10, fixed engine latency in cycles from issue to result (NR_AES)
OM_W, 16, output-mask index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a garbling run
keys_ok  in  1  label generator has R and AES key ready
g_valid  in  1  gate descriptor valid
g_ready  out  1  gate accepted this cycle
g_last  in  1  final gate of netlist
g_logic  in  4  gate type (shared gate-type constants)
g_in0, g_in1  in  S  input wire indices (signed; in1 = -1 means constant R)
g_in0F, g_in1F  in  1  operand is a primary input
g_is_output  in  1  gate drives a circuit output
op_rdy0, op_rdy1  in  1  label-present flags for current head operands
eng_issue  out  NE  one-hot lane start pulse
eng_gid  out  S  gid of issued gate
eng_logic  out  4  gate type of issued gate
xor_wr_en  out  1  write free-XOR label at xor_wr_addr
xor_wr_addr  out  S  gid of XOR gate
ol_wr_en  out  1  engine output label write
ol_wr_addr  out  S  gid of completing gate
gt_wr_en  out  1  garbled-table write (two rows)
gt_wr_addr  out  S+1  row-0 address = 2*gt_idx; row 1 = +1
om_wr_en  out  1  capture output mask bit
om_wr_sel_xor  out  1  mask source: 1 = XOR label lsb, 0 = engine label lsb
om_wr_idx  out  OM_W  output-mask slot
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset: all outputs 0, all lanes free, gid = 0, num_xor = 0, om counter = 0, state IDLE.
- rst mid-run discards in-flight lanes with no write strobes. Reset is synchronous and active-high.
- FSM: IDLE --start--> KEYS --keys_ok--> RUN --g_last accepted--> DRAIN --all lanes free--> DONE --> IDLE.
- DONE lasts one cycle; done=1 in DONE. busy=1 in KEYS, RUN, DRAIN.
- Head-gate readiness (RUN only): ready = (g_in0F|op_rdy0) & (g_in1==-1 | g_in1F | op_rdy1).
- XOR-class gate: g_ready = g_valid & ready.
  - On accept: xor_wr_en=1 with xor_wr_addr=gid in the same cycle; num_xor += 1.
  - If g_is_output: om_wr_en=1, om_wr_sel_xor=1, om_wr_idx = om counter; counter += 1.
- Other gates: g_ready = g_valid & ready & (any lane free).
  - Issue to the lowest-index free lane.
  - Lane record latches gid, gt_idx = gid - num_xor, is_output, and om_idx (assigned now; counter += 1 if output). Lane countdown loads LAT.
- Lane retire: at countdown 0 (exactly LAT cycles after issue), assert ol_wr_en/ol_wr_addr, gt_wr_en/gt_wr_addr, and om_wr_en with om_wr_sel_xor=0 if is_output; lane becomes free the same cycle.
- Issue is at most one per cycle and LAT is fixed, so at most one retire per cycle.
- A lane freed by a retire may be reissued in the same cycle.
- Simultaneous XOR om write and lane om retire: the lane retire wins. The XOR gate is held (g_ready=0) that cycle.
- gid increments on every accepted gate. Width wraps mod 2^S; overflow is undefined use.
- A start pulse outside IDLE is ignored.

Optional Feature:
- GC_PERF_CNT_EN defined: adds 32-bit outputs stall_dep_cnt (head valid, not ready) and stall_lane_cnt (ready, no free lane), both saturating and cleared on start.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package holds the gate-type enum (XOR/XNOR/NOT/AND...), the is_free_xor function, and the FSM state typedef.
- One sub-module: gc_lane_slot, which holds one lane's record, countdown and free flag; instantiated NE times.

Test Plan:
- NE=2, LAT=10; 3 independent AND gates at cycles 0,1,2 -> issues on lanes 0,1 at cycles 0,1; gate 3 stalls to cycle 10. Retires at 10, 11, 20 with gt_wr_addr 0, 2, 4.
- Stream AND, XOR, AND (gids 0-2) -> xor_wr_en at gid 1; second AND gets gt_idx 1 (gt_wr_addr 2).
- Gate with op_rdy1=0 for 5 cycles -> g_ready low 5 cycles; no issue; stall_dep_cnt = 5 with GC_PERF_CNT_EN.
- Output AND then output XOR -> om_wr_idx 1 (XOR) fires immediately; om_wr_idx 0 fires LAT cycles after the AND issue.
- rst asserted 3 cycles after an issue -> no ol/gt writes afterwards; busy=0, state IDLE.
- g_last on an AND gate -> DRAIN; done pulses exactly 1 cycle after its retire.
